// File: rtl/edge_event_logger.sv
// Edge event logger: timestamps rising/falling transitions on two sampled signals
// into a first-word-fall-through FIFO. Optional mask filtering under EDGE_LOG_FILTER_EN.
module edge_event_logger #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [1:0]             sig_in,
`ifdef EDGE_LOG_FILTER_EN
  input  logic [1:0]             rise_mask,
  input  logic [1:0]             fall_mask,
`endif
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [TS_W+5:0]        ev_data,
  output logic [$clog2(DEPTH):0] ev_level,
  output logic                   overflow,
  output logic [7:0]             drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = TS_W + 6;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [RW-1:0]   mem [DEPTH];
  logic [AW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]     level_reg, level_next;
  logic            valid_reg;
  logic [RW-1:0]   head_reg, head_next;
  logic [TS_W-1:0] ts_reg;
  logic [1:0]      prev_reg;
  logic            primed_reg;
  logic            overflow_reg;
  logic [7:0]      drop_cnt_reg;

  logic [1:0]      rise, fall, rise_k, fall_k;
  logic            detect, want, pop, push, drop;
  logic [RW-1:0]   rec;
  logic [AW:0]     level_after_pop;
  logic [AW-1:0]   rd_next;

  always_comb begin
    rise   = ~prev_reg & sig_in;
    fall   = prev_reg & ~sig_in;
    detect = primed_reg && (sig_in != prev_reg);
`ifdef EDGE_LOG_FILTER_EN
    rise_k = rise & rise_mask;
    fall_k = fall & fall_mask;
    want   = detect && (|(rise_k | fall_k));
`else
    rise_k = rise;
    fall_k = fall;
    want   = detect;
`endif
    rec  = {ts_reg, fall_k, rise_k, sig_in};
    pop  = valid_reg & ev_ready;
    // A full FIFO can still take the record when the head leaves in the same cycle
    push = want && ((level_reg != FULL_LVL) || pop);
    drop = want && !push;
  end

  always_comb begin
    level_next = level_reg;
    case ({push, pop})
      2'b10:   level_next = level_reg + (AW+1)'(1);
      2'b01:   level_next = level_reg - (AW+1)'(1);
      default: level_next = level_reg;
    endcase
    level_after_pop = level_reg - (AW+1)'(pop);
    rd_next         = rd_ptr_reg + AW'(pop);
    // Registered head: the new record becomes head only when nothing older remains
    head_next = head_reg;
    if (level_after_pop == '0) begin
      if (push) head_next = rec;
    end else begin
      head_next = mem[rd_next];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr_reg] <= rec;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      valid_reg    <= 1'b0;
      head_reg     <= '0;
      ts_reg       <= '0;
      prev_reg     <= '0;
      primed_reg   <= 1'b0;
      overflow_reg <= 1'b0;
      drop_cnt_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg <= rd_next;
      level_reg  <= level_next;
      valid_reg  <= (level_next != '0);
      head_reg   <= head_next;
      ts_reg     <= ts_reg + TS_W'(1);
      prev_reg   <= sig_in;
      primed_reg <= 1'b1;
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_cnt_reg != 8'hFF) drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end
  end

  assign ev_valid = valid_reg;
  assign ev_data  = head_reg;
  assign ev_level = level_reg;
  assign overflow = overflow_reg;
  assign drop_cnt = drop_cnt_reg;

endmodule

// File: tb/tb_edge_event_logger.sv
// Directed bench for edge_event_logger (DEPTH=8, TS_W=4) with immediate-assertion checks.
module tb_edge_event_logger;

  localparam int DEPTH = 8;
  localparam int TS_W  = 4;

  logic             clk;
  logic             reset;
  logic [1:0]       sig_in;
  logic [1:0]       rise_mask, fall_mask;
  logic             ev_valid;
  logic             ev_ready;
  logic [TS_W+5:0]  ev_data;
  logic [3:0]       ev_level;
  logic             overflow;
  logic [7:0]       drop_cnt;

  int compared = 0;
  int mismatched = 0;

  edge_event_logger #(.DEPTH(DEPTH), .TS_W(TS_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .sig_in   (sig_in),
`ifdef EDGE_LOG_FILTER_EN
    .rise_mask(rise_mask),
    .fall_mask(fall_mask),
`endif
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_data  (ev_data),
    .ev_level (ev_level),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [9:0] rec(input int ts, input logic [1:0] f, input logic [1:0] r,
                                     input logic [1:0] c);
    logic [3:0] t;
    t = ts[3:0];
    return {t, f, r, c};
  endfunction

  function automatic logic [9:0] toggle_rec(input int k);
    if (k % 2 == 0) return rec(10 + k, 2'b00, 2'b01, 2'b11);
    else            return rec(10 + k, 2'b01, 2'b00, 2'b10);
  endfunction

  initial begin
    reset = 1'b1; sig_in = 2'b00; ev_ready = 1'b0;
    rise_mask = 2'b11; fall_mask = 2'b11;
    step(); step();
    reset = 1'b0;
    check("rst_valid", 32'(ev_valid), 32'd0);
    check("rst_level", 32'(ev_level), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_data", 32'(ev_data), 32'd0);
    $display("reset done");

    // First record at edge 3 carries ts=2
    step(); step();
    sig_in = 2'b01; step();
    check("t1_valid", 32'(ev_valid), 32'd1);
    check("t1_level", 32'(ev_level), 32'd1);
    check("t1_data", 32'(ev_data), 32'(rec(2, 2'b00, 2'b01, 2'b01)));
    ev_ready = 1'b1; step(); ev_ready = 1'b0;
    check("t1_pop_valid", 32'(ev_valid), 32'd0);
    check("t1_pop_level", 32'(ev_level), 32'd0);
    $display("txn: single rise record checked");

    // 01->00, 00->11, 11->10 : three records, consecutive ts 4,5,6
    sig_in = 2'b00; step();
    sig_in = 2'b11; step();
    sig_in = 2'b10; step();
    check("t2_level", 32'(ev_level), 32'd3);
    check("t2_head0", 32'(ev_data), 32'(rec(4, 2'b01, 2'b00, 2'b00)));
    ev_ready = 1'b1; step();
    check("t2_head1", 32'(ev_data), 32'(rec(5, 2'b00, 2'b11, 2'b11)));
    check("t2_level1", 32'(ev_level), 32'd2);
    step();
    check("t2_head2", 32'(ev_data), 32'(rec(6, 2'b01, 2'b00, 2'b10)));
    check("t2_level2", 32'(ev_level), 32'd1);
    step(); ev_ready = 1'b0;
    check("t2_empty", 32'(ev_valid), 32'd0);
    $display("txn: dual-edge and fall records checked");

    // Overfill: 11 records into 8 entries, 3 dropped
    for (int i = 0; i < DEPTH + 3; i++) begin
      sig_in[0] = ~sig_in[0];
      step();
    end
    check("t3_level", 32'(ev_level), 32'd8);
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_drop", 32'(drop_cnt), 32'd3);
    check("t3_head", 32'(ev_data), 32'(toggle_rec(0)));
    $display("txn: overflow checked");

    // Full with simultaneous pop and push: accepted, level stays full
    sig_in = 2'b10; ev_ready = 1'b1; step();
    check("t4_level", 32'(ev_level), 32'd8);
    check("t4_drop", 32'(drop_cnt), 32'd3);
    for (int k = 1; k < DEPTH; k++) begin
      check($sformatf("t4_drain%0d", k), 32'(ev_data), 32'(toggle_rec(k)));
      step();
    end
    check("t4_last", 32'(ev_data), 32'(rec(21, 2'b01, 2'b00, 2'b10)));
    step();
    ev_ready = 1'b0;
    check("t4_empty", 32'(ev_valid), 32'd0);
    check("t4_empty_lvl", 32'(ev_level), 32'd0);
    $display("txn: full push/pop and drain checked");

    // Timestamp wrap with 20 idle cycles; first edge after reset only primes
    sig_in = 2'b01; reset = 1'b1; step(); reset = 1'b0;
    check("t5_rst_ovf", 32'(overflow), 32'd0);
    check("t5_rst_drop", 32'(drop_cnt), 32'd0);
    step();
    check("t5_prime", 32'(ev_valid), 32'd0);
    for (int i = 1; i < 20; i++) step();
    sig_in = 2'b00; step();
    check("t5_wrap_ts", 32'(ev_data), 32'(rec(20, 2'b01, 2'b00, 2'b00)));
    check("t5_level", 32'(ev_level), 32'd1);
    ev_ready = 1'b1; step(); ev_ready = 1'b0;
    sig_in = 2'b01; step();
    sig_in = 2'b00; step();
    sig_in = 2'b01; step();
    check("t5_queued", 32'(ev_level), 32'd3);
    reset = 1'b1; step(); reset = 1'b0;
    check("t5_flush_valid", 32'(ev_valid), 32'd0);
    check("t5_flush_level", 32'(ev_level), 32'd0);
    check("t5_flush_drop", 32'(drop_cnt), 32'd0);
    check("t5_flush_data", 32'(ev_data), 32'd0);
    $display("txn: ts wrap and mid-run reset checked");

`ifdef EDGE_LOG_FILTER_EN
    rise_mask = 2'b01; fall_mask = 2'b00;
    sig_in = 2'b00; step();
    sig_in = 2'b11; step();
    sig_in = 2'b00; step();
    step();
    check("f_level", 32'(ev_level), 32'd1);
    check("f_data", 32'(ev_data), 32'(rec(1, 2'b00, 2'b01, 2'b11)));
    check("f_drop", 32'(drop_cnt), 32'd0);
    $display("txn: mask filter checked");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
